// File: rtl/win_gen_pkg.sv
// Shared constants for the 3x3 window generator: default geometry,
// counter-width helper and window index positions.
package win_gen_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF = cnt_w(IMG_W_DEF);
  localparam int ROW_W_DEF = cnt_w(IMG_H_DEF);

  localparam int WIN_N   = 9;
  localparam int TL_IDX  = 0;
  localparam int CTR_IDX = 4;
  localparam int BR_IDX  = 8;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
interface window_gen_3x3_if
  import win_gen_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
);
  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);

  logic [PIX_W-1:0] Pix_In;
  logic             Pix_Valid;
  logic             Sof;
  logic [PIX_W-1:0] X0, X1, X2, X3, X4, X5, X6, X7, X8;
  logic             Win_Valid;
  logic [ROW_W-1:0] Ctr_Row;
  logic [COL_W-1:0] Ctr_Col;
  logic             Frame_Done;

  modport master (
    output Pix_In, Pix_Valid, Sof,
    input  X0, X1, X2, X3, X4, X5, X6, X7, X8,
    input  Win_Valid, Ctr_Row, Ctr_Col, Frame_Done
  );

  modport slave (
    input  Pix_In, Pix_Valid, Sof,
    output X0, X1, X2, X3, X4, X5, X6, X7, X8,
    output Win_Valid, Ctr_Row, Ctr_Col, Frame_Done
  );
endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// One image line of storage: single address, asynchronous read of the old
// entry and write of the new one on the same enabled edge.
module line_buffer
  import win_gen_pkg::*;
#(
  parameter int DEPTH  = IMG_W_DEF,
  parameter int WIDTH  = PIX_W_DEF,
  parameter int ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // NOTE: storage arrays carry no reset; every entry is rewritten before its contents reach a valid window.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-order pixel stream in, registered 3x3 neighbourhood out with
// centre coordinates and an end-of-frame pulse.
module window_gen_3x3
  import win_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic            Clk,
  input  logic            Rst,
  window_gen_3x3_if.slave win
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef logic [PIX_W-1:0] pix_t;

  logic             accept;
  logic [COL_W-1:0] col_cur, col_q, col_d, ctr_col_q, ctr_col_d;
  logic [ROW_W-1:0] row_cur, row_q, row_d, ctr_row_q, ctr_row_d;
  pix_t             win_q [WIN_N];
  pix_t             win_d [WIN_N];
  pix_t             lb0_rd, lb1_rd;
  logic             win_valid_q, win_valid_d, frame_done_q, frame_done_d;

  assign accept  = win.Pix_Valid;
  assign col_cur = win.Sof ? '0 : col_q;
  assign row_cur = win.Sof ? '0 : row_q;

  // LB1 holds the previous row; LB0 takes over whatever LB1 held at this column.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk(Clk), .en(accept), .addr(col_cur), .wr_data(win.Pix_In), .rd_data(lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk(Clk), .en(accept), .addr(col_cur), .wr_data(lb1_rd), .rd_data(lb0_rd)
  );

  // NOTE: every signal gets a hold default before the conditional updates, so no latch is inferred.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    ctr_row_d    = ctr_row_q;
    ctr_col_d    = ctr_col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
      end else begin
        col_d = col_cur + COL_W'(1);
        row_d = row_cur;
      end

      win_d[TL_IDX]      = win_q[TL_IDX + 1];
      win_d[TL_IDX + 1]  = win_q[TL_IDX + 2];
      win_d[TL_IDX + 2]  = lb0_rd;
      win_d[CTR_IDX - 1] = win_q[CTR_IDX];
      win_d[CTR_IDX]     = win_q[CTR_IDX + 1];
      win_d[CTR_IDX + 1] = lb1_rd;
      win_d[BR_IDX - 2]  = win_q[BR_IDX - 1];
      win_d[BR_IDX - 1]  = win_q[BR_IDX];
      win_d[BR_IDX]      = win.Pix_In;

      win_valid_d  = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
      frame_done_d = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
      // Centre coordinates only move with a real window so they hold otherwise.
      if (win_valid_d) begin
        ctr_row_d = row_cur - ROW_W'(1);
        ctr_col_d = col_cur - COL_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      ctr_row_q    <= '0;
      ctr_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      ctr_row_q    <= ctr_row_d;
      ctr_col_q    <= ctr_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win.X0         = win_q[0];
  assign win.X1         = win_q[1];
  assign win.X2         = win_q[2];
  assign win.X3         = win_q[3];
  assign win.X4         = win_q[4];
  assign win.X5         = win_q[5];
  assign win.X6         = win_q[6];
  assign win.X7         = win_q[7];
  assign win.X8         = win_q[8];
  assign win.Win_Valid  = win_valid_q;
  assign win.Ctr_Row    = ctr_row_q;
  assign win.Ctr_Col    = ctr_col_q;
  assign win.Frame_Done = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: a 5x4 instance for the main scenarios
// and a 3x3 instance for the minimum frame.
module tb_window_gen_3x3;
  import win_gen_pkg::*;

  typedef logic [71:0] win_t;

  logic clk;
  logic rst_n;

  window_gen_3x3_if #(.PIX_W(8), .IMG_W(5), .IMG_H(4)) if_a ();
  window_gen_3x3_if #(.PIX_W(8), .IMG_W(3), .IMG_H(3)) if_b ();

  window_gen_3x3 #(.IMG_W(5), .IMG_H(4), .PIX_W(8)) dut_a (.Clk(clk), .Rst(rst_n), .win(if_a.slave));
  window_gen_3x3 #(.IMG_W(3), .IMG_H(3), .PIX_W(8)) dut_b (.Clk(clk), .Rst(rst_n), .win(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   failures;
  win_t got_win[$];
  int   got_row[$];
  int   got_col[$];
  int   got_fd[$];
  int   fd_count;

  function automatic win_t cur_x(input bit sel_b);
    if (sel_b) return {if_b.X0, if_b.X1, if_b.X2, if_b.X3, if_b.X4, if_b.X5, if_b.X6, if_b.X7, if_b.X8};
    return {if_a.X0, if_a.X1, if_a.X2, if_a.X3, if_a.X4, if_a.X5, if_a.X6, if_a.X7, if_a.X8};
  endfunction

  function automatic logic cur_wv(input bit sel_b);
    return sel_b ? if_b.Win_Valid : if_a.Win_Valid;
  endfunction

  function automatic logic cur_fd(input bit sel_b);
    return sel_b ? if_b.Frame_Done : if_a.Frame_Done;
  endfunction

  function automatic int cur_row(input bit sel_b);
    return sel_b ? int'(if_b.Ctr_Row) : int'(if_a.Ctr_Row);
  endfunction

  function automatic int cur_col(input bit sel_b);
    return sel_b ? int'(if_b.Ctr_Col) : int'(if_a.Ctr_Col);
  endfunction

  // Expected window for the pixel accepted at (r,c) of a stream base + row*16 + col.
  function automatic win_t exp_win(input int base, input int r, input int c);
    win_t res;
    res = '0;
    for (int k = 0; k < 9; k++) res = {res[63:0], 8'(base + (r - 2 + k / 3) * 16 + (c - 2 + k % 3))};
    return res;
  endfunction

  task automatic clear_log();
    got_win.delete();
    got_row.delete();
    got_col.delete();
    got_fd.delete();
    fd_count = 0;
  endtask

  // One clock: drive the selected instance (the other idles), sample #1 after the edge.
  task automatic step(input bit sel_b, input logic [7:0] pix, input logic v, input logic sof);
    if_a.Pix_In    = sel_b ? 8'h00 : pix;
    if_a.Pix_Valid = !sel_b && v;
    if_a.Sof       = !sel_b && sof;
    if_b.Pix_In    = sel_b ? pix : 8'h00;
    if_b.Pix_Valid = sel_b && v;
    if_b.Sof       = sel_b && sof;
    @(posedge clk);
    #1;
    if (cur_wv(sel_b)) begin
      got_win.push_back(cur_x(sel_b));
      got_row.push_back(cur_row(sel_b));
      got_col.push_back(cur_col(sel_b));
      got_fd.push_back(int'(cur_fd(sel_b)));
    end
    if (cur_fd(sel_b)) fd_count++;
  endtask

  task automatic send_frame(input bit sel_b, input int w, input int h, input int base, input bit sof_first);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        step(sel_b, 8'(base + r * 16 + c), 1'b1, sof_first && r == 0 && c == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({if_a.Win_Valid, if_a.Frame_Done, if_a.Ctr_Row, if_a.Ctr_Col, cur_x(1'b0)} !== '0) begin
      failures++;
      $display("FAIL reset_a: got wv=%b fd=%b row=%0d col=%0d x=%h, want all zero",
               if_a.Win_Valid, if_a.Frame_Done, if_a.Ctr_Row, if_a.Ctr_Col, cur_x(1'b0));
    end
    checks++;
    if ({if_b.Win_Valid, if_b.Frame_Done, if_b.Ctr_Row, if_b.Ctr_Col, cur_x(1'b1)} !== '0) begin
      failures++;
      $display("FAIL reset_b: got wv=%b fd=%b row=%0d col=%0d x=%h, want all zero",
               if_b.Win_Valid, if_b.Frame_Done, if_b.Ctr_Row, if_b.Ctr_Col, cur_x(1'b1));
    end
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_frame_basic();
    clear_log();
    send_frame(1'b0, 5, 4, 0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (got_win.size() != 6) begin
      failures++;
      $display("FAIL basic_count: got %0d windows, want 6", got_win.size());
    end else begin
      checks++;
      if (got_win[0] !== 72'h00_01_02_10_11_12_20_21_22 || got_row[0] != 1 || got_col[0] != 1) begin
        failures++;
        $display("FAIL basic_first: got x=%h ctr=(%0d,%0d), want x=000102101112202122 ctr=(1,1)",
                 got_win[0], got_row[0], got_col[0]);
      end
      checks++;
      if (got_win[5][39:32] !== 8'h23 || got_row[5] != 2 || got_col[5] != 3 || got_fd[5] != 1) begin
        failures++;
        $display("FAIL basic_last: got x4=%h ctr=(%0d,%0d) fd=%0d, want x4=23 ctr=(2,3) fd=1",
                 got_win[5][39:32], got_row[5], got_col[5], got_fd[5]);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_win[i] !== exp_win(0, 2 + i / 3, 2 + i % 3) || got_fd[i] != ((i == 5) ? 1 : 0)) begin
          failures++;
          $display("FAIL basic_win%0d: got x=%h fd=%0d, want x=%h", i, got_win[i], got_fd[i],
                   exp_win(0, 2 + i / 3, 2 + i % 3));
        end
      end
    end
    checks++;
    if (fd_count != 1) begin
      failures++;
      $display("FAIL basic_fd_count: got %0d, want 1", fd_count);
    end
  endtask

  task automatic test_gaps();
    win_t xb;
    int   rb, cb;
    clear_log();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        for (int g = 0; g < 1 + int'($urandom_range(0, 1)); g++) begin
          xb = cur_x(1'b0);
          rb = cur_row(1'b0);
          cb = cur_col(1'b0);
          step(1'b0, 8'hEE, 1'b0, 1'b0);
          checks++;
          if (if_a.Win_Valid !== 1'b0 || if_a.Frame_Done !== 1'b0) begin
            failures++;
            $display("FAIL gap_strobe: got wv=%b fd=%b after idle, want 0 0", if_a.Win_Valid, if_a.Frame_Done);
          end
          checks++;
          if (cur_x(1'b0) !== xb || cur_row(1'b0) != rb || cur_col(1'b0) != cb) begin
            failures++;
            $display("FAIL gap_hold: got x=%h ctr=(%0d,%0d), want x=%h ctr=(%0d,%0d)",
                     cur_x(1'b0), cur_row(1'b0), cur_col(1'b0), xb, rb, cb);
          end
        end
        step(1'b0, 8'(r * 16 + c), 1'b1, r == 0 && c == 0);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (got_win.size() != 6 || fd_count != 1) begin
      failures++;
      $display("FAIL gaps_count: got %0d windows %0d done, want 6 1", got_win.size(), fd_count);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_win[i] !== exp_win(0, 2 + i / 3, 2 + i % 3) || got_row[i] != 1 + i / 3 || got_col[i] != 1 + i % 3) begin
          failures++;
          $display("FAIL gaps_win%0d: got x=%h ctr=(%0d,%0d), want x=%h ctr=(%0d,%0d)", i, got_win[i],
                   got_row[i], got_col[i], exp_win(0, 2 + i / 3, 2 + i % 3), 1 + i / 3, 1 + i % 3);
        end
      end
    end
  endtask

  task automatic test_sof_mid();
    clear_log();
    for (int i = 0; i < 12; i++) step(1'b0, 8'(8'h80 + (i / 5) * 16 + i % 5), 1'b1, i == 0);
    send_frame(1'b0, 5, 4, 0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (got_win.size() != 6 || fd_count != 1) begin
      failures++;
      $display("FAIL sof_mid_count: got %0d windows %0d done, want 6 1", got_win.size(), fd_count);
    end else begin
      checks++;
      if (got_win[0][71:64] !== 8'h00) begin
        failures++;
        $display("FAIL sof_mid_x0: got %h, want 00", got_win[0][71:64]);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_win[i] !== exp_win(0, 2 + i / 3, 2 + i % 3)) begin
          failures++;
          $display("FAIL sof_mid_win%0d: got %h, want %h", i, got_win[i], exp_win(0, 2 + i / 3, 2 + i % 3));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_frame(1'b0, 5, 4, 0, 1'b1);
    send_frame(1'b0, 5, 4, 0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (got_win.size() != 12 || fd_count != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d windows %0d done, want 12 2", got_win.size(), fd_count);
    end else begin
      checks++;
      if (got_win[6] !== 72'h00_01_02_10_11_12_20_21_22 || got_fd[5] != 1 || got_fd[11] != 1) begin
        failures++;
        $display("FAIL b2b_second: got x=%h fd5=%0d fd11=%0d, want x=000102101112202122 1 1",
                 got_win[6], got_fd[5], got_fd[11]);
      end
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (got_win[i] !== exp_win(0, 2 + (i % 6) / 3, 2 + i % 3)) begin
          failures++;
          $display("FAIL b2b_win%0d: got %h, want %h", i, got_win[i], exp_win(0, 2 + (i % 6) / 3, 2 + i % 3));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    for (int i = 0; i < 14; i++) step(1'b0, 8'(8'h40 + (i / 5) * 16 + i % 5), 1'b1, i == 0);
    if_a.Pix_Valid = 1'b0;
    if_a.Sof       = 1'b0;
    checks++;
    if (if_a.Win_Valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got wv=%b before reset, want 1", if_a.Win_Valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_a.Win_Valid, if_a.Frame_Done, if_a.Ctr_Row, if_a.Ctr_Col, cur_x(1'b0)} !== '0) begin
      failures++;
      $display("FAIL rst_mid_async: got wv=%b row=%0d col=%0d x=%h, want all zero",
               if_a.Win_Valid, if_a.Ctr_Row, if_a.Ctr_Col, cur_x(1'b0));
    end
    #1;
    rst_n = 1'b1;
    clear_log();
    send_frame(1'b0, 5, 4, 0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (got_win.size() != 6 || fd_count != 1) begin
      failures++;
      $display("FAIL rst_mid_count: got %0d windows %0d done, want 6 1", got_win.size(), fd_count);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_win[i] !== exp_win(0, 2 + i / 3, 2 + i % 3) || got_row[i] != 1 + i / 3 || got_col[i] != 1 + i % 3) begin
          failures++;
          $display("FAIL rst_mid_win%0d: got x=%h ctr=(%0d,%0d), want x=%h", i, got_win[i],
                   got_row[i], got_col[i], exp_win(0, 2 + i / 3, 2 + i % 3));
        end
      end
    end
  endtask

  task automatic test_min_frame();
    clear_log();
    send_frame(1'b1, 3, 3, 0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (got_win.size() != 1 || fd_count != 1) begin
      failures++;
      $display("FAIL min_count: got %0d windows %0d done, want 1 1", got_win.size(), fd_count);
    end else begin
      checks++;
      if (got_win[0] !== 72'h00_01_02_10_11_12_20_21_22 || got_row[0] != 1 || got_col[0] != 1 || got_fd[0] != 1) begin
        failures++;
        $display("FAIL min_win: got x=%h ctr=(%0d,%0d) fd=%0d, want x=000102101112202122 ctr=(1,1) fd=1",
                 got_win[0], got_row[0], got_col[0], got_fd[0]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fd_count = 0;
    rst_n    = 1'b0;
    if_a.Pix_In = 8'h00; if_a.Pix_Valid = 1'b0; if_a.Sof = 1'b0;
    if_b.Pix_In = 8'h00; if_b.Pix_Valid = 1'b0; if_b.Sof = 1'b0;
    test_reset();
    test_frame_basic();
    test_gaps();
    test_sof_mid();
    test_back_to_back();
    test_reset_mid();
    test_min_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
